// File: rtl/ap_eval_pkg.sv
// ============================================================================
// Module   : ap_eval_pkg
// Brief    : Shared types, widths and partial-product helper for the
//            4x4 approximate-multiplier error evaluator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ap_eval_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int NVEC   = 256;
    localparam int PP_W   = OP_W * OP_W;
    localparam int CNT_W  = 9;
    localparam int SUM_W  = 16;
    localparam int BIAS_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            valid;
    } tag_t;

    // Row i of the partial-product array is operand a gated by bit i of b.
    function automatic logic [PP_W-1:0] pp_gen(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b);
        logic [PP_W-1:0] pp;
        pp = '0;
        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                pp[OP_W*i+j] = a[j] & b[i];
            end
        end
        return pp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ap_err_eval_4b_acc.sv
// ============================================================================
// Module   : ap_err_acc
// Brief    : Per-cycle error distance / statistics accumulator fed by the
//            aligned operand tag and the DUT result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ap_err_acc
    import ap_eval_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_valid,
    input  logic [OP_W-1:0]          i_a,
    input  logic [OP_W-1:0]          i_b,
    input  logic [PROD_W-1:0]        i_res,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic [SUM_W-1:0]         o_sum_ed,
    output logic [PROD_W-1:0]        o_max_ed,
    output logic [OP_W-1:0]          o_worst_a,
    output logic [OP_W-1:0]          o_worst_b,
    output logic signed [BIAS_W-1:0] o_bias
);

    logic [PROD_W-1:0]        w_exact;
    logic signed [PROD_W:0]   w_diff;
    logic [PROD_W-1:0]        w_ed;

    logic [CNT_W-1:0]         r_err_cnt_q, w_err_cnt_d;
    logic [SUM_W-1:0]         r_sum_ed_q,  w_sum_ed_d;
    logic [PROD_W-1:0]        r_max_ed_q,  w_max_ed_d;
    logic [OP_W-1:0]          r_worst_a_q, w_worst_a_d;
    logic [OP_W-1:0]          r_worst_b_q, w_worst_b_d;
    logic signed [BIAS_W-1:0] r_bias_q,    w_bias_d;

    // Reference product comes from the tag, never from the DUT.
    assign w_exact = PROD_W'(i_a) * PROD_W'(i_b);
    assign w_diff  = $signed({1'b0, i_res}) - $signed({1'b0, w_exact});
    assign w_ed    = w_diff[PROD_W] ? PROD_W'(-w_diff) : w_diff[PROD_W-1:0];

    always_comb begin
        w_err_cnt_d = r_err_cnt_q;
        w_sum_ed_d  = r_sum_ed_q;
        w_max_ed_d  = r_max_ed_q;
        w_worst_a_d = r_worst_a_q;
        w_worst_b_d = r_worst_b_q;
        w_bias_d    = r_bias_q;
        if (i_clr) begin
            w_err_cnt_d = '0;
            w_sum_ed_d  = '0;
            w_max_ed_d  = '0;
            w_worst_a_d = '0;
            w_worst_b_d = '0;
            w_bias_d    = '0;
        end else if (i_valid) begin
            if (w_ed != '0) begin
                w_err_cnt_d = r_err_cnt_q + CNT_W'(1);
            end
            w_sum_ed_d = r_sum_ed_q + SUM_W'(w_ed);
            w_bias_d   = r_bias_q + BIAS_W'(w_diff);
            // Strict compare: earliest index keeps a tie.
            if (w_ed > r_max_ed_q) begin
                w_max_ed_d  = w_ed;
                w_worst_a_d = i_a;
                w_worst_b_d = i_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt_q <= '0;
            r_sum_ed_q  <= '0;
            r_max_ed_q  <= '0;
            r_worst_a_q <= '0;
            r_worst_b_q <= '0;
            r_bias_q    <= '0;
        end else begin
            r_err_cnt_q <= w_err_cnt_d;
            r_sum_ed_q  <= w_sum_ed_d;
            r_max_ed_q  <= w_max_ed_d;
            r_worst_a_q <= w_worst_a_d;
            r_worst_b_q <= w_worst_b_d;
            r_bias_q    <= w_bias_d;
        end
    end

    assign o_err_cnt = r_err_cnt_q;
    assign o_sum_ed  = r_sum_ed_q;
    assign o_max_ed  = r_max_ed_q;
    assign o_worst_a = r_worst_a_q;
    assign o_worst_b = r_worst_b_q;
    assign o_bias    = r_bias_q;

endmodule

`default_nettype wire

// File: rtl/ap_err_eval_4b.sv
// ============================================================================
// Module   : ap_err_eval_4b
// Brief    : Exhaustive 256-vector error evaluator for a 4x4 approximate
//            multiplier compressor tree (FSM, issue counter, tag pipeline).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ap_err_eval_4b
    import ap_eval_pkg::*;
#(
    parameter int DUT_LAT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [PP_W-1:0]     pp,
    input  logic [PROD_W-1:0]   res,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [SUM_W-1:0]    sum_ed,
    output logic [PROD_W-1:0]   max_ed,
    output logic [OP_W-1:0]     worst_a,
    output logic [OP_W-1:0]     worst_b,
    output logic [BIAS_W-1:0]   bias
);

    localparam logic [CNT_W-1:0] C_CNT_END = CNT_W'(NVEC);

    state_t            r_state_q, w_state_d;
    logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [PP_W-1:0]   r_pp_q,    w_pp_d;
    tag_t              r_tag_q,   w_tag_d;
    tag_t              w_aligned;
    logic              w_start_ok;
    logic              w_last;
    logic              w_acc_valid;
    logic signed [BIAS_W-1:0] w_bias;

    assign w_start_ok  = start && ((r_state_q == ST_IDLE) || (r_state_q == ST_DONE));
    assign w_last      = w_aligned.valid && (&w_aligned.a) && (&w_aligned.b);
    assign w_acc_valid = (r_state_q == ST_RUN) && w_aligned.valid;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_pp_d    = '0;
        w_tag_d   = '0;
        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_d     = ST_RUN;
                    w_cnt_d       = CNT_W'(1);
                    w_pp_d        = pp_gen('0, '0);
                    w_tag_d.valid = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt_q != C_CNT_END) begin
                    w_pp_d        = pp_gen(r_cnt_q[OP_W-1:0], r_cnt_q[2*OP_W-1:OP_W]);
                    w_tag_d.a     = r_cnt_q[OP_W-1:0];
                    w_tag_d.b     = r_cnt_q[2*OP_W-1:OP_W];
                    w_tag_d.valid = 1'b1;
                    w_cnt_d       = r_cnt_q + CNT_W'(1);
                end
                // Leave RUN on the edge that accumulates vector 255.
                if (w_last) begin
                    w_state_d = ST_DONE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_pp_q    <= '0;
            r_tag_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_pp_q    <= w_pp_d;
            r_tag_q   <= w_tag_d;
        end
    end

    // Tag delay line matching the DUT register depth.
    generate
        if (DUT_LAT == 0) begin : g_no_pipe
            assign w_aligned = r_tag_q;
        end else begin : g_pipe
            tag_t r_pipe_q [DUT_LAT];
            tag_t w_pipe_d [DUT_LAT];

            always_comb begin
                w_pipe_d[0] = r_tag_q;
                for (int i = 1; i < DUT_LAT; i++) begin
                    w_pipe_d[i] = r_pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        r_pipe_q[i] <= '0;
                    end
                end else begin
                    r_pipe_q <= w_pipe_d;
                end
            end

            assign w_aligned = r_pipe_q[DUT_LAT-1];
        end
    endgenerate

    ap_err_acc u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_start_ok),
        .i_valid   (w_acc_valid),
        .i_a       (w_aligned.a),
        .i_b       (w_aligned.b),
        .i_res     (res),
        .o_err_cnt (err_cnt),
        .o_sum_ed  (sum_ed),
        .o_max_ed  (max_ed),
        .o_worst_a (worst_a),
        .o_worst_b (worst_b),
        .o_bias    (w_bias)
    );

    assign bias = w_bias;
    assign pp   = r_pp_q;
    assign busy = (r_state_q == ST_RUN);
    assign done = (r_state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ap_err_eval_4b.sv
// ============================================================================
// Module   : tb_ap_err_eval_4b
// Brief    : Self-checking bench; behavioural compressor-tree models for
//            DUT_LAT=0 and DUT_LAT=2 evaluators, checked against a sweep model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ap_err_eval_4b;

    typedef struct packed {
        logic [8:0]  err_cnt;
        logic [15:0] sum_ed;
        logic [7:0]  max_ed;
        logic [3:0]  wa;
        logic [3:0]  wb;
        logic [16:0] bias;
    } stats_t;

    localparam int M_EXACT = 0;
    localparam int M_STUCK = 1;
    localparam int M_PLUS1 = 2;
    localparam int M_DROP  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start0, start2;
    logic [15:0] pp0, pp2, pp2_r1, pp2_r2;
    logic [7:0]  res0, res2;
    logic busy0, done0, busy2, done2;
    logic [8:0]  err_cnt0, err_cnt2;
    logic [15:0] sum_ed0, sum_ed2;
    logic [7:0]  max_ed0, max_ed2;
    logic [3:0]  worst_a0, worst_b0, worst_a2, worst_b2;
    logic [16:0] bias0, bias2;
    stats_t obs0, obs2;

    int mode;
    logic [15:0] mask;
    int tests_run = 0;
    int fails = 0;

    // Compressor-tree model: weighted sum of the (possibly pruned) pp bits.
    function automatic logic [7:0] dut_fn(input logic [15:0] p, input int md, input logic [15:0] mk);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (p[4*i+j] && !(md == M_DROP && mk[4*i+j])) s += (1 << (i + j));
        if (md == M_STUCK) s = 0;
        if (md == M_PLUS1) s = s + 1;
        return 8'(s);
    endfunction

    // Whole-sweep statistics computed directly from operand arithmetic.
    function automatic stats_t ref_stats(input int md, input logic [15:0] mk);
        stats_t s;
        int cnt, sum, bs, mx, wa, wb, a, b, e, r, d, ed;
        cnt = 0; sum = 0; bs = 0; mx = 0; wa = 0; wb = 0;
        for (int k = 0; k < 256; k++) begin
            a = k % 16;
            b = k / 16;
            e = a * b;
            case (md)
                M_EXACT: r = e;
                M_STUCK: r = 0;
                M_PLUS1: r = e + 1;
                default: begin
                    r = 0;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            if (((a >> j) & 1) == 1 && ((b >> i) & 1) == 1 && !mk[4*i+j])
                                r += (1 << (i + j));
                end
            endcase
            d  = r - e;
            ed = (d < 0) ? -d : d;
            if (ed != 0) cnt++;
            sum += ed;
            bs  += d;
            if (ed > mx) begin mx = ed; wa = a; wb = b; end
        end
        s.err_cnt = 9'(cnt);
        s.sum_ed  = 16'(sum);
        s.max_ed  = 8'(mx);
        s.wa      = 4'(wa);
        s.wb      = 4'(wb);
        s.bias    = 17'(bs);
        return s;
    endfunction

    always_comb res0 = dut_fn(pp0, mode, mask);
    always_comb res2 = dut_fn(pp2_r2, mode, mask);
    always @(posedge clk) begin
        pp2_r1 <= pp2;
        pp2_r2 <= pp2_r1;
    end

    assign obs0 = {err_cnt0, sum_ed0, max_ed0, worst_a0, worst_b0, bias0};
    assign obs2 = {err_cnt2, sum_ed2, max_ed2, worst_a2, worst_b2, bias2};

    ap_err_eval_4b #(.DUT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .pp(pp0), .res(res0),
        .busy(busy0), .done(done0), .err_cnt(err_cnt0), .sum_ed(sum_ed0),
        .max_ed(max_ed0), .worst_a(worst_a0), .worst_b(worst_b0), .bias(bias0)
    );

    ap_err_eval_4b #(.DUT_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .pp(pp2), .res(res2),
        .busy(busy2), .done(done2), .err_cnt(err_cnt2), .sum_ed(sum_ed2),
        .max_ed(max_ed2), .worst_a(worst_a2), .worst_b(worst_b2), .bias(bias2)
    );

    // Start a sweep on the selected evaluator and wait (bounded) for done.
    task automatic run_sweep(input int sel, input int pulse_at, output int cycles,
                             output int busy_cycles, output logic done_e0, output stats_t obs_e0);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0; start2 = 1'b0;
        done_e0 = (sel == 0) ? done0 : done2;
        obs_e0  = (sel == 0) ? obs0 : obs2;
        cycles = 0; busy_cycles = 0;
        while (((sel == 0) ? done0 : done2) !== 1'b1 && cycles < 2000) begin
            @(negedge clk);
            if (((sel == 0) ? busy0 : busy2) === 1'b1) busy_cycles++;
            if (cycles == pulse_at) begin
                if (sel == 0) start0 = 1'b1; else start2 = 1'b1;
            end
            @(posedge clk);
            #1;
            cycles++;
            start0 = 1'b0; start2 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
        mode = M_EXACT; mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({obs0, pp0, busy0, done0} !== '0) begin
            fails++;
            $display("FAIL reset_dut0: got obs=%h pp=%h busy=%b done=%b, want all 0", obs0, pp0, busy0, done0);
        end
        tests_run++;
        if ({obs2, pp2, busy2, done2} !== '0) begin
            fails++;
            $display("FAIL reset_dut2: got obs=%h pp=%h busy=%b done=%b, want all 0", obs2, pp2, busy2, done2);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy0, done0, pp0} !== '0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b done=%b pp=%h, want 0", busy0, done0, pp0);
        end
    endtask

    task automatic test_exact();
        int cyc, bc; logic de0; stats_t oe0;
        mode = M_EXACT;
        run_sweep(0, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (cyc != 256 || bc != 256) begin
            fails++;
            $display("FAIL exact_timing: got cycles=%0d busy=%0d, want 256/256", cyc, bc);
        end
        tests_run++;
        if (obs0 !== '0) begin
            fails++;
            $display("FAIL exact_results: got %h, want 0", obs0);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || pp0 !== '0) begin
            fails++;
            $display("FAIL done_level: got done=%b busy=%b pp=%h, want 1/0/0", done0, busy0, pp0);
        end
    endtask

    task automatic test_stuck();
        int cyc, bc; logic de0; stats_t oe0, exp_s;
        mode = M_STUCK;
        exp_s.err_cnt = 9'd225; exp_s.sum_ed = 16'd14400; exp_s.max_ed = 8'd225;
        exp_s.wa = 4'd15; exp_s.wb = 4'd15; exp_s.bias = -17'sd14400;
        run_sweep(0, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (obs0 !== exp_s || cyc != 256) begin
            fails++;
            $display("FAIL stuck_results: got %h cycles=%0d, want %h cycles=256", obs0, cyc, exp_s);
        end
    endtask

    task automatic test_plus1();
        int cyc, bc; logic de0; stats_t oe0, exp_s;
        mode = M_PLUS1;
        exp_s.err_cnt = 9'd256; exp_s.sum_ed = 16'd256; exp_s.max_ed = 8'd1;
        exp_s.wa = 4'd0; exp_s.wb = 4'd0; exp_s.bias = 17'd256;
        run_sweep(0, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (obs0 !== exp_s) begin
            fails++;
            $display("FAIL plus1_results: got %h, want %h", obs0, exp_s);
        end
    endtask

    task automatic test_random_masks();
        int cyc, bc; logic de0; stats_t oe0, exp_s;
        for (int n = 0; n < 4; n++) begin
            mode = M_DROP;
            mask = 16'($urandom);
            exp_s = ref_stats(mode, mask);
            run_sweep(0, -1, cyc, bc, de0, oe0);
            tests_run++;
            if (obs0 !== exp_s || cyc != 256) begin
                fails++;
                $display("FAIL random_mask%0d mask=%h: got %h cycles=%0d, want %h cycles=256", n, mask, obs0, cyc, exp_s);
            end
        end
    endtask

    task automatic test_lat2();
        int cyc, bc; logic de0; stats_t oe0, exp_s;
        mode = M_EXACT;
        run_sweep(2, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (cyc != 258 || bc != 258 || obs2 !== '0) begin
            fails++;
            $display("FAIL lat2_exact: got cycles=%0d busy=%0d obs=%h, want 258/258/0", cyc, bc, obs2);
        end
        mode = M_DROP;
        mask = 16'($urandom) | 16'h0001;
        exp_s = ref_stats(mode, mask);
        run_sweep(2, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (obs2 !== exp_s || cyc != 258) begin
            fails++;
            $display("FAIL lat2_mask mask=%h: got %h cycles=%0d, want %h cycles=258", mask, obs2, cyc, exp_s);
        end
        exp_s = ref_stats(M_STUCK, '0);
        mode = M_STUCK;
        run_sweep(2, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (de0 !== 1'b0 || oe0 !== '0 || obs2 !== exp_s) begin
            fails++;
            $display("FAIL lat2_restart: got done@E0=%b obs@E0=%h final=%h, want 0/0/%h", de0, oe0, obs2, exp_s);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bc; logic de0; stats_t oe0, exp_s;
        mode = M_STUCK;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        tests_run++;
        if ({obs0, pp0, busy0, done0} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got obs=%h pp=%h busy=%b done=%b, want all 0", obs0, pp0, busy0, done0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_s = ref_stats(M_STUCK, '0);
        run_sweep(0, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (obs0 !== exp_s || cyc != 256) begin
            fails++;
            $display("FAIL post_reset_sweep: got %h cycles=%0d, want %h cycles=256", obs0, cyc, exp_s);
        end
    endtask

    task automatic test_start_mid_run();
        int cyc, bc; logic de0; stats_t oe0, exp_s;
        mode = M_DROP;
        mask = 16'($urandom) | 16'h8000;
        exp_s = ref_stats(mode, mask);
        run_sweep(0, 50, cyc, bc, de0, oe0);
        tests_run++;
        if (obs0 !== exp_s || cyc != 256) begin
            fails++;
            $display("FAIL start_mid_run: got %h cycles=%0d, want %h cycles=256", obs0, cyc, exp_s);
        end
        run_sweep(0, 255, cyc, bc, de0, oe0);
        tests_run++;
        if (obs0 !== exp_s || cyc != 256) begin
            fails++;
            $display("FAIL start_last_cycle: got %h cycles=%0d, want %h cycles=256", obs0, cyc, exp_s);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc; logic de0; stats_t oe0, exp_s;
        exp_s = ref_stats(mode, mask);
        run_sweep(0, -1, cyc, bc, de0, oe0);
        tests_run++;
        if (de0 !== 1'b0 || oe0 !== '0) begin
            fails++;
            $display("FAIL restart_clear: got done@E0=%b obs@E0=%h, want 0/0", de0, oe0);
        end
        tests_run++;
        if (obs0 !== exp_s || cyc != 256 || bc != 256) begin
            fails++;
            $display("FAIL restart_repeat: got %h cycles=%0d busy=%0d, want %h 256/256", obs0, cyc, bc, exp_s);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exact();
        test_stuck();
        test_plus1();
        test_random_masks();
        test_lat2();
        test_reset_mid();
        test_start_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

`default_nettype wire
